// File: rtl/lfsr_pkg.sv
// Shared constants and types for the parametrised LFSR generator.
// Default taps are maximal-length polynomials for the common widths.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [3:0]  FIB_TAPS_4  = 4'h3;
  localparam logic [3:0]  GAL_MASK_4  = 4'hC;
  localparam logic [7:0]  FIB_TAPS_8  = 8'h1D;
  localparam logic [7:0]  GAL_MASK_8  = 8'hB8;
  localparam logic [15:0] FIB_TAPS_16 = 16'h002D;
  localparam logic [15:0] GAL_MASK_16 = 16'hB400;

  typedef enum logic {ST_IDLE, ST_BUSY} burst_state_e;

  // Widths without a tabulated polynomial fall back to the 8-bit one and should override.
  function automatic logic [31:0] defaultFibTaps(input int w);
    case (w)
      4:       return 32'(FIB_TAPS_4);
      16:      return 32'(FIB_TAPS_16);
      default: return 32'(FIB_TAPS_8);
    endcase
  endfunction

  function automatic logic [31:0] defaultGalMask(input int w);
    case (w)
      4:       return 32'(GAL_MASK_4);
      16:      return 32'(GAL_MASK_16);
      default: return 32'(GAL_MASK_8);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: Fibonacci or Galois successor of the current state.
// An all-zero state is forced to 1 so the generator can never stay locked up.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = 8'h1D,
  parameter logic [WIDTH-1:0] GAL_MASK = 8'hB8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             is_zero_o
);

  logic             fibBit;
  logic [WIDTH-1:0] fibNext;
  logic [WIDTH-1:0] galNext;

  assign fibBit    = ^(r_i & FIB_TAPS);
  assign fibNext   = {fibBit, r_i[WIDTH-1:1]};
  assign galNext   = (r_i >> 1) ^ (r_i[0] ? GAL_MASK : '0);
  assign is_zero_o = (r_i == '0);

  always_comb begin
    next_o = fibNext;
    if (is_zero_o) begin
      next_o = WIDTH'(1);
    end else begin
      case (mode_i)
        MODE_FIB: next_o = fibNext;
        MODE_GAL: next_o = galNext;
        default:  next_o = fibNext;
      endcase
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator top: state/origin registers, counted burst FSM and status pulses.
// O is the state register itself, so a step is visible right after its clock edge.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS   = WIDTH'(defaultFibTaps(WIDTH)),
  parameter logic [WIDTH-1:0] GAL_MASK   = WIDTH'(defaultGalMask(WIDTH)),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] O
);

  burst_state_e     burstState_q, burstState_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] origin_q, origin_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] stepNext;
  logic             stateIsZero;
  logic             doStep;

  lfsr_next #(
    .WIDTH   (WIDTH),
    .FIB_TAPS(FIB_TAPS),
    .GAL_MASK(GAL_MASK)
  ) u_next (
    .r_i      (state_q),
    .mode_i   (mode),
    .next_o   (stepNext),
    .is_zero_o(stateIsZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burstState_q <= ST_IDLE;
      state_q      <= RESET_SEED;
      origin_q     <= RESET_SEED;
      remaining_q  <= '0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      lockup_q     <= 1'b0;
    end else begin
      burstState_q <= burstState_d;
      state_q      <= state_d;
      origin_q     <= origin_d;
      remaining_q  <= remaining_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      lockup_q     <= lockup_d;
    end
  end

  // Priority per edge: load, then an active burst, then start accept, then free-run.
  always_comb begin
    burstState_d = burstState_q;
    state_d      = state_q;
    origin_d     = origin_q;
    remaining_d  = remaining_q;
    done_d       = 1'b0;
    wrap_d       = 1'b0;
    lockup_d     = 1'b0;
    doStep       = 1'b0;

    if (load) begin
      state_d      = seed;
      origin_d     = seed;
      burstState_d = ST_IDLE;
      remaining_d  = '0;
    end else if (burstState_q == ST_BUSY) begin
      doStep      = 1'b1;
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        burstState_d = ST_IDLE;
        done_d       = 1'b1;
      end
    end else if (start) begin
      if (cnt == '0) begin
        done_d = 1'b1;
      end else begin
        remaining_d  = cnt;
        burstState_d = ST_BUSY;
      end
    end else if (en) begin
      doStep = 1'b1;
    end

    if (doStep) begin
      state_d  = stepNext;
      lockup_d = stateIsZero;
      wrap_d   = !stateIsZero && (stepNext == origin_q);
    end
  end

  always_comb begin
    busy   = (burstState_q == ST_BUSY);
    done   = done_q;
    wrap   = wrap_q;
    lockup = lockup_q;
    O      = state_q;
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a reference model pushes expected outputs per edge,
// which are popped and compared after the edge.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, mode, start;
  logic [7:0] seed, cnt;
  logic       busy, done, wrap, lockup;
  logic [7:0] O;

  typedef struct packed {
    logic [7:0] o;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       lockup;
  } exp_t;

  exp_t  sbQ[$];
  int    compareCount = 0;
  int    failCount = 0;
  string phase = "init";

  logic [7:0] mState, mOrigin;
  int         mRem;
  logic       mBusy, mDone, mWrap, mLock;

  lfsr_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed), .mode(mode),
    .start(start), .cnt(cnt), .busy(busy), .done(done), .wrap(wrap),
    .lockup(lockup), .O(O)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", phase, tag, observed, expected);
    end
  endtask

  // Independent reference step: bitwise tap loop for Fibonacci, shift/toggle for Galois.
  function automatic logic [7:0] refStep(input logic [7:0] r, input logic md);
    logic [7:0] taps;
    logic       fb;
    taps = 8'h1D;
    fb   = 1'b0;
    if (md == 1'b0) begin
      for (int i = 0; i < 8; i++) if (taps[i]) fb = fb ^ r[i];
      return {fb, r[7:1]};
    end
    return r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
  endfunction

  task automatic modelReset();
    mState = 8'h01; mOrigin = 8'h01; mRem = 0;
    mBusy = 0; mDone = 0; mWrap = 0; mLock = 0;
  endtask

  task automatic modelStep(input logic md);
    if (mState == 8'h00) begin
      mState = 8'h01;
      mLock  = 1'b1;
    end else begin
      mState = refStep(mState, md);
      mWrap  = (mState == mOrigin);
    end
  endtask

  task automatic modelEdge(input logic ld, input logic [7:0] sd, input logic md,
                           input logic st, input logic [7:0] ct, input logic e);
    mDone = 0; mWrap = 0; mLock = 0;
    if (ld) begin
      mState = sd; mOrigin = sd; mBusy = 0; mRem = 0;
    end else if (mBusy) begin
      modelStep(md);
      mRem--;
      if (mRem == 0) begin
        mBusy = 0;
        mDone = 1;
      end
    end else if (st) begin
      if (ct == 8'd0) mDone = 1;
      else begin
        mRem  = int'(ct);
        mBusy = 1;
      end
    end else if (e) begin
      modelStep(md);
    end
  endtask

  task automatic checkNow();
    checkOutput("O", O, mState);
    checkOutput("busy", busy, mBusy);
    checkOutput("done", done, mDone);
    checkOutput("wrap", wrap, mWrap);
    checkOutput("lockup", lockup, mLock);
  endtask

  task automatic popAndCheck();
    exp_t ex;
    if (sbQ.size() == 0) begin
      checkOutput("sbUnderflow", sbQ.size(), 1);
    end else begin
      ex = sbQ.pop_front();
      checkOutput("O", O, ex.o);
      checkOutput("busy", busy, ex.busy);
      checkOutput("done", done, ex.done);
      checkOutput("wrap", wrap, ex.wrap);
      checkOutput("lockup", lockup, ex.lockup);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] sd, input logic md,
                               input logic st, input logic [7:0] ct, input logic e);
    load = ld; seed = sd; mode = md; start = st; cnt = ct; en = e;
    modelEdge(ld, sd, md, st, ct, e);
    sbQ.push_back('{o: mState, busy: mBusy, done: mDone, wrap: mWrap, lockup: mLock});
    @(posedge clk);
    #1;
    popAndCheck();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 8'd0, 0);
  endtask

  task automatic midCycleReset();
    load = 0; start = 0; en = 0; cnt = 0; seed = 0;
    #3;
    rst = 1;
    modelReset();
    #1;
    checkNow();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [7:0] fibFirst[5];
    logic [7:0] galFirst[5];
    logic [7:0] saved;
    int         firstWrap, busyCycles, donePulses;

    fibFirst[0] = 8'h80; fibFirst[1] = 8'h40; fibFirst[2] = 8'h20; fibFirst[3] = 8'h10; fibFirst[4] = 8'h88;
    galFirst[0] = 8'hB8; galFirst[1] = 8'h5C; galFirst[2] = 8'h2E; galFirst[3] = 8'h17; galFirst[4] = 8'hB3;

    rst = 1; en = 0; load = 0; mode = 0; start = 0; seed = 0; cnt = 0;
    modelReset();
    #3;
    phase = "reset";
    checkNow();
    @(negedge clk);
    rst = 0;

    phase = "fibRun";
    firstWrap = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 8'd0, 1);
      if (i <= 5) checkOutput($sformatf("seq%0d", i), O, fibFirst[i-1]);
      if (wrap && firstWrap == 0) firstWrap = i;
    end
    checkOutput("wrapStep", firstWrap, 255);
    checkOutput("wrapValue", O, 8'h01);

    phase = "galRun";
    applyStimulus(1, 8'h01, 1, 0, 8'd0, 0);
    firstWrap = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(0, 8'h00, 1, 0, 8'd0, 1);
      if (i <= 5) checkOutput($sformatf("seq%0d", i), O, galFirst[i-1]);
      if (wrap && firstWrap == 0) firstWrap = i;
    end
    checkOutput("wrapStep", firstWrap, 255);

    phase = "lockup";
    applyStimulus(1, 8'h00, 0, 0, 8'd0, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'd0, 1);
    checkOutput("recovered", O, 8'h01);
    checkOutput("lockPulse", lockup, 1);
    idle(1);

    phase = "burst5";
    applyStimulus(1, 8'h01, 0, 0, 8'd0, 0);
    busyCycles = 0; donePulses = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'd5, 0);
    busyCycles += busy;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 8'h00, 0, (i <= 4), 8'd7, 0);
      busyCycles += busy;
      donePulses += done;
    end
    checkOutput("busyCycles", busyCycles, 5);
    checkOutput("donePulses", donePulses, 1);
    checkOutput("endValue", O, 8'h88);

    phase = "burst0";
    saved = O;
    busyCycles = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'd0, 0);
    busyCycles += busy;
    checkOutput("donePulse", done, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'd0, 0);
    busyCycles += busy;
    checkOutput("busyCycles", busyCycles, 0);
    checkOutput("unchanged", O, saved);

    phase = "startEn";
    saved = O;
    applyStimulus(0, 8'h00, 0, 1, 8'd3, 1);
    checkOutput("noStep", O, saved);
    idle(4);

    phase = "abortLoad";
    donePulses = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'd10, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'd0, 0);
    applyStimulus(1, 8'h3C, 0, 0, 8'd0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 8'd0, 0);
      donePulses += done;
    end
    checkOutput("donePulses", donePulses, 0);
    checkOutput("loaded", O, 8'h3C);

    phase = "abortRst";
    donePulses = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'd10, 0);
    idle(2);
    midCycleReset();
    checkOutput("rstValue", O, 8'h01);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 8'd0, 0);
      donePulses += done;
    end
    checkOutput("donePulses", donePulses, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised pseudo-random generator; next generation of the 8-bit nvboard LFSR.
- Generalised in width and taps, with:
  - a runtime-selectable Fibonacci or Galois mode;
  - seed load;
  - a counted burst mode with a start/busy/done handshake;
  - period-wrap and lock-up status pulses.
- Feeds nvboard demos (LED/7-seg patterns) and test-stimulus generators.

Parameters:
- WIDTH, 8: state/output width, 2 to 32.
- FIB_TAPS, 8'h1D: Fibonacci tap mask. Bit i set means R[i] is XORed into the feedback.
- GAL_MASK, 8'hB8: Galois toggle mask, XORed into the shifted state when the LSB is 1.
- RESET_SEED, 8'h01: state after reset. Must be nonzero.
- CNT_W, 8: width of the burst step count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset. This is the only reset.
- en  in  1  free-run step enable. One step per cycle while high and not busy.
- load  in  1  load seed into state. Highest priority.
- seed  in  WIDTH  value loaded on load.
- mode  in  1  0 = Fibonacci, 1 = Galois. Sampled at each step.
- start  in  1  request a burst of cnt steps. Accepted only when busy = 0.
- cnt  in  CNT_W  burst length, latched on an accepted start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final burst step.
- wrap  out  1  one-cycle pulse: the step just taken produced the origin value.
- lockup  out  1  one-cycle pulse: an all-zero state was recovered.
- O  out  WIDTH  current state. This is the state register itself, so no extra latency.

Behaviour:
- Reset (async, rst = 1) sets:
  - O = RESET_SEED, origin = RESET_SEED;
  - busy = 0, done = 0, wrap = 0, lockup = 0, remaining = 0.
- Step function, applied to state R:
  - If R == 0: next = 1 (WIDTH-wide). lockup = 1 and wrap = 0 for that step.
  - Fibonacci: s = XOR-reduce(R & FIB_TAPS); next = {s, R[WIDTH-1:1]}.
  - Galois: next = (R >> 1) ^ (R[0] ? GAL_MASK : 0).
- Per-edge priority: load > burst (busy) > start accept > en.
- load:
  - O = seed and origin = seed.
  - Any burst is aborted: busy = 0, no done.
  - No step is taken. Zero seeds are accepted and recovered on the next step.
- Start accept (busy = 0, load = 0, start = 1):
  - If cnt == 0: no step, busy stays 0, done = 1 next cycle.
  - Else: remaining = cnt, busy = 1. No step on this edge, and en is ignored on it.
- Busy cycles:
  - One step per edge regardless of en; remaining decrements.
  - On the step where remaining == 1: busy drops and done = 1 for one cycle.
  - A start at edge k therefore gives steps on edges k+1 .. k+cnt; done is high after edge k+cnt.
  - start is ignored while busy.
- Free run: en = 1, busy = 0, no load and no start gives one step per edge.
- Pulse outputs:
  - wrap = 1 after any step whose result equals origin.
  - done, wrap and lockup are registered, and each defaults to 0 every cycle unless set.
- Mode change: takes effect on the next step, including mid-burst.
- Reset mid-burst: immediate return to the reset state; no done.

Decomposition:
- Package lfsr_pkg holds:
  - MODE_FIB = 1'b0, MODE_GAL = 1'b1;
  - default tap and mask constants for widths 4, 8 and 16 (x^8+x^4+x^3+x^2+1 → 8'h1D; Galois 8'hB8).
- Sub-module lfsr_next:
  - combinational; parametrised by WIDTH, FIB_TAPS and GAL_MASK;
  - inputs R and mode; outputs next and is_zero.
- The top holds the state, origin, burst counter/FSM (IDLE, BUSY) and the pulse registers.

Test Plan:
- Reset, Fibonacci free-run:
  - Stimulus: assert rst mid-cycle, release, mode = 0, en = 1.
  - Response: O = 01 immediately on rst; all flags 0. Then O = 80, 40, 20, 10, 88. wrap first pulses exactly 255 steps after reset, with O = 01.
- Galois free-run:
  - Stimulus: mode = 1, load seed 01, then en = 1.
  - Response: O = B8, 5C, 2E, 17, B3. Period 255, wrap at step 255.
- Zero-seed lock-up:
  - Stimulus: load seed 00, then one en step.
  - Response: O = 00, then O = 01 with lockup = 1 for one cycle and wrap = 0.
- Burst with en held low:
  - Stimulus: seed 01, Fibonacci, start with cnt = 5.
  - Response: busy high for 5 cycles; O ends at 88; done pulses once; a second start during busy is ignored.
- Zero-length burst and en interaction:
  - Stimulus: start with cnt = 0.
  - Response: done pulses next cycle, busy never high, O unchanged.
  - Stimulus: start with en = 1 on the accepting edge.
  - Response: no step on that edge.
- Aborts:
  - Stimulus: load seed 3C during cycle 2 of a cnt = 10 burst.
  - Response: O = 3C, busy = 0, no done.
  - Stimulus: rst mid-burst.
  - Response: O = 01, busy = 0.
